// File: rtl/syn_gpu_pkg.sv
// Shared pixel-path types and the Q8 BT.709 YCbCr->RGB coefficient set.
// Coefficients are signed integers scaled by 2^P_COEF_FRAC_DFLT.
// Consumers size them to their accumulator width at the point of use.
package syn_gpu_pkg;

  localparam int P_LUM_W          = 4;
  localparam int P_CHRM_W         = 2;
  localparam int P_RGB_RES        = 4;
  localparam int P_COEF_FRAC_DFLT = 8;
  localparam int P_ACC_W_DFLT     = 16;

  typedef struct packed {
    logic [P_LUM_W-1:0]  y;
    logic [P_CHRM_W-1:0] cb;
    logic [P_CHRM_W-1:0] cr;
  } pxl_ycbcr_t;

  typedef struct packed {
    logic [P_RGB_RES-1:0] red;
    logic [P_RGB_RES-1:0] green;
    logic [P_RGB_RES-1:0] blue;
  } pxl_rgb_t;

  // Luma gain is common to all three channels.
  localparam int C_KY      = 272;
  localparam int C_R_KCB   = 0;
  localparam int C_R_KCR   = 2142;
  localparam int C_R_OFF   = -3213;
  localparam int C_G_KCB   = -254;
  localparam int C_G_KCR   = -637;
  localparam int C_G_OFF   = 1337;
  localparam int C_B_KCB   = 2523;
  localparam int C_B_KCR   = 0;
  localparam int C_B_OFF   = -3785;

endpackage

// File: rtl/syn_cc_mac.sv
// One colour channel: luma term plus two chroma terms plus offset, then round and clamp.
// Latency 3 cycles (products, sum, round/clamp), each stage registered.
// Backpressure: every stage holds while en_i is low; outputs stay stable.
module syn_cc_mac
  import syn_gpu_pkg::*;
#(
  parameter int P_COEF_FRAC = P_COEF_FRAC_DFLT,
  parameter int P_ACC_W     = P_ACC_W_DFLT,
  parameter int P_KY        = 0,
  parameter int P_KCB       = 0,
  parameter int P_KCR       = 0,
  parameter int P_OFF       = 0
) (
  input  logic                 clk_ir,
  input  logic                 rst_il,
  input  logic                 en_i,
  input  logic [P_LUM_W-1:0]   y_i,
  input  logic [P_CHRM_W-1:0]  cb_i,
  input  logic [P_CHRM_W-1:0]  cr_i,
  output logic [P_RGB_RES-1:0] chn_o,
  output logic                 clip_o
);

  localparam logic signed [P_ACC_W-1:0] KY      = P_ACC_W'(P_KY);
  localparam logic signed [P_ACC_W-1:0] KCB     = P_ACC_W'(P_KCB);
  localparam logic signed [P_ACC_W-1:0] KCR     = P_ACC_W'(P_KCR);
  localparam logic signed [P_ACC_W-1:0] OFF     = P_ACC_W'(P_OFF);
  localparam logic signed [P_ACC_W-1:0] RND     = P_ACC_W'(1 << (P_COEF_FRAC - 1));
  localparam logic signed [P_ACC_W-1:0] OUT_MAX = P_ACC_W'((1 << P_RGB_RES) - 1);

  logic signed [P_ACC_W-1:0] y_ext, cb_ext, cr_ext, rnd;
  logic signed [P_ACC_W-1:0] py_d, py_q, pcb_d, pcb_q, pcr_d, pcr_q, sum_d, sum_q;
  logic [P_RGB_RES-1:0]      chn_d, chn_q;
  logic                      clip_d, clip_q;

  // Next state of all three stages: products, offset sum, round-half-up and clamp
  always_comb begin
    y_ext  = {{(P_ACC_W-P_LUM_W){1'b0}}, y_i};
    cb_ext = {{(P_ACC_W-P_CHRM_W){1'b0}}, cb_i};
    cr_ext = {{(P_ACC_W-P_CHRM_W){1'b0}}, cr_i};
    py_d   = y_ext * KY;
    pcb_d  = cb_ext * KCB;
    pcr_d  = cr_ext * KCR;
    sum_d  = py_q + pcb_q + pcr_q + OFF;
    rnd    = (sum_q + RND) >>> P_COEF_FRAC;
    chn_d  = rnd[P_RGB_RES-1:0];
    clip_d = 1'b0;
    if (rnd[P_ACC_W-1]) begin
      chn_d  = '0;
      clip_d = 1'b1;
    end else if (rnd > OUT_MAX) begin
      chn_d  = '1;
      clip_d = 1'b1;
    end
  end

  // Pipeline registers advance together only when the stage enable is high
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      py_q   <= '0;
      pcb_q  <= '0;
      pcr_q  <= '0;
      sum_q  <= '0;
      chn_q  <= '0;
      clip_q <= 1'b0;
    end else if (en_i) begin
      py_q   <= py_d;
      pcb_q  <= pcb_d;
      pcr_q  <= pcr_d;
      sum_q  <= sum_d;
      chn_q  <= chn_d;
      clip_q <= clip_d;
    end
  end

  assign chn_o  = chn_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/syn_ycbcr2rgb.sv
// YCbCr(4:2:2 bit) -> RGB444 pixel converter, BT.709 Q8 coefficients; SYN_YCBCR2RGB_STATS_EN adds counters.
// Latency 3 cycles from accept to rgb_vld_od, 1 pixel/clk.
// Backpressure: output valid with rgb_rdy_id low freezes every stage and drops ycbcr_rdy_od.
module syn_ycbcr2rgb
  import syn_gpu_pkg::*;
#(
  parameter int P_COEF_FRAC = P_COEF_FRAC_DFLT,
  parameter int P_ACC_W     = P_ACC_W_DFLT
) (
  input  logic        clk_ir,
  input  logic        rst_il,
  input  logic        ycbcr_vld_id,
  input  logic [7:0]  ycbcr_pxl_id,
  input  logic        ycbcr_sof_id,
  output logic        ycbcr_rdy_od,
  output logic        rgb_vld_od,
  output logic [11:0] rgb_pxl_od,
  output logic        rgb_sof_od,
  input  logic        rgb_rdy_id
`ifdef SYN_YCBCR2RGB_STATS_EN
  ,
  output logic [15:0] clip_cnt_od,
  output logic [15:0] pxl_cnt_od
`endif
);

  pxl_ycbcr_t pxl_in;
  pxl_rgb_t   pxl_out;
  logic       stall, en;
  logic [2:0] vld_d, vld_q, sof_d, sof_q;
  logic [2:0] clip;

  assign pxl_in       = ycbcr_pxl_id;
  assign stall        = vld_q[2] & ~rgb_rdy_id;
  assign en           = ~stall;
  assign ycbcr_rdy_od = en;

  // Valid/sof shift one stage per advance; bit 0 is S1, a bubble carries sof=0
  always_comb begin
    vld_d = {vld_q[1:0], ycbcr_vld_id};
    sof_d = {sof_q[1:0], ycbcr_vld_id & ycbcr_sof_id};
  end

  // Sideband registers hold with the datapath on stall
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      vld_q <= '0;
      sof_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      sof_q <= sof_d;
    end
  end

  syn_cc_mac #(.P_COEF_FRAC(P_COEF_FRAC), .P_ACC_W(P_ACC_W),
               .P_KY(C_KY), .P_KCB(C_R_KCB), .P_KCR(C_R_KCR), .P_OFF(C_R_OFF))
    u_mac_r (.clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .y_i(pxl_in.y), .cb_i(pxl_in.cb),
             .cr_i(pxl_in.cr), .chn_o(pxl_out.red), .clip_o(clip[0]));

  syn_cc_mac #(.P_COEF_FRAC(P_COEF_FRAC), .P_ACC_W(P_ACC_W),
               .P_KY(C_KY), .P_KCB(C_G_KCB), .P_KCR(C_G_KCR), .P_OFF(C_G_OFF))
    u_mac_g (.clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .y_i(pxl_in.y), .cb_i(pxl_in.cb),
             .cr_i(pxl_in.cr), .chn_o(pxl_out.green), .clip_o(clip[1]));

  syn_cc_mac #(.P_COEF_FRAC(P_COEF_FRAC), .P_ACC_W(P_ACC_W),
               .P_KY(C_KY), .P_KCB(C_B_KCB), .P_KCR(C_B_KCR), .P_OFF(C_B_OFF))
    u_mac_b (.clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .y_i(pxl_in.y), .cb_i(pxl_in.cb),
             .cr_i(pxl_in.cr), .chn_o(pxl_out.blue), .clip_o(clip[2]));

  assign rgb_vld_od = vld_q[2];
  assign rgb_sof_od = sof_q[2];
  assign rgb_pxl_od = pxl_out;

`ifdef SYN_YCBCR2RGB_STATS_EN
  logic        xfer;
  logic [15:0] clip_cnt_d, clip_cnt_q, pxl_cnt_d, pxl_cnt_q;

  assign xfer = rgb_vld_od & rgb_rdy_id;

  // Saturating counters stepped on each delivered pixel
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    pxl_cnt_d  = pxl_cnt_q;
    if (xfer) begin
      if (pxl_cnt_q != 16'hFFFF) pxl_cnt_d = pxl_cnt_q + 16'd1;
      if ((|clip) && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  // Counters clear only on reset
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      clip_cnt_q <= '0;
      pxl_cnt_q  <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
      pxl_cnt_q  <= pxl_cnt_d;
    end
  end

  assign clip_cnt_od = clip_cnt_q;
  assign pxl_cnt_od  = pxl_cnt_q;
`else
  // Clip flags only feed the statistics counters
  logic clip_unused;
  assign clip_unused = |clip;
`endif

endmodule

// File: tb/tb_syn_ycbcr2rgb.sv
// Directed-vector bench for syn_ycbcr2rgb: latency, values, sof, throughput, backpressure, reset.
// Inputs change 1 time unit after the rising edge; outputs are read there or on the falling edge.
// Counter checks are included when SYN_YCBCR2RGB_STATS_EN is defined.
module tb_syn_ycbcr2rgb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic [7:0]  in_pxl;
  logic        in_sof;
  logic        in_rdy;
  logic        out_vld;
  logic [11:0] out_pxl;
  logic        out_sof;
  logic        out_rdy;
`ifdef SYN_YCBCR2RGB_STATS_EN
  logic [15:0] clip_cnt;
  logic [15:0] pxl_cnt;
  int          exp_pxl  = 0;
  int          exp_clip = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [11:0] out_q[$];
  logic        out_sof_q[$];
  int          out_cyc_q[$];
  logic [7:0]  acc_q[$];

  // Hand-computed vectors {y,cb,cr} -> {r,g,b}
  logic [7:0]  vin  [5] = '{8'h00, 8'hFF, 8'h86, 8'h49, 8'hF0};
  logic [11:0] vexp [5] = '{12'h050, 12'hFBF, 12'hD84, 12'h059, 12'h3F1};
  int          vclip[5] = '{1, 1, 0, 0, 1};

  always #5 clk = ~clk;

  syn_ycbcr2rgb dut (
    .clk_ir      (clk),
    .rst_il      (rst_n),
    .ycbcr_vld_id(in_vld),
    .ycbcr_pxl_id(in_pxl),
    .ycbcr_sof_id(in_sof),
    .ycbcr_rdy_od(in_rdy),
    .rgb_vld_od  (out_vld),
    .rgb_pxl_od  (out_pxl),
    .rgb_sof_od  (out_sof),
    .rgb_rdy_id  (out_rdy)
`ifdef SYN_YCBCR2RGB_STATS_EN
    ,
    .clip_cnt_od (clip_cnt),
    .pxl_cnt_od  (pxl_cnt)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record transfers that will happen at the coming rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
      out_q.push_back(out_pxl);
      out_sof_q.push_back(out_sof);
      out_cyc_q.push_back(cyc);
    end
    if (rst_n === 1'b1 && in_vld === 1'b1 && in_rdy === 1'b1) acc_q.push_back(in_pxl);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Real-valued reference for one channel (0=R,1=G,2=B), rounded half up and clamped
  function automatic int model_chan(input logic [7:0] code, input int ch);
    real y, cb, cr, v;
    int  r;
    y  = real'(int'(code[7:4]));
    cb = real'(int'(code[3:2]));
    cr = real'(int'(code[1:0]));
    if (ch == 0)      v = (272.0 * y + 2142.0 * cr - 3213.0) / 256.0;
    else if (ch == 1) v = (272.0 * y - 254.0 * cb - 637.0 * cr + 1337.0) / 256.0;
    else              v = (272.0 * y + 2523.0 * cb - 3785.0) / 256.0;
    r = $rtoi($floor(v + 0.5));
    if (r < 0)  r = 0;
    if (r > 15) r = 15;
    return r;
  endfunction

  function automatic bit near_model(input logic [11:0] act, input logic [7:0] code);
    int a, d;
    for (int ch = 0; ch < 3; ch++) begin
      a = int'(act[11-4*ch -: 4]);
      d = a - model_chan(code, ch);
      if (d > 1 || d < -1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_vld = 1'b0; in_pxl = '0; in_sof = 1'b0; out_rdy = 1'b1;
    repeat (3) tick;
    checks++;
    if (out_vld !== 1'b0 || out_pxl !== 12'h000 || out_sof !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%b pxl=%h sof=%b expected 0/000/0", out_vld, out_pxl, out_sof);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b vld=%b expected 1/0", in_rdy, out_vld);
    end
`ifdef SYN_YCBCR2RGB_STATS_EN
    checks++;
    if (clip_cnt !== 16'd0 || pxl_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got clip=%0d pxl=%0d expected 0/0", clip_cnt, pxl_cnt);
    end
`endif
  endtask

  task automatic test_directed;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_pxl = vin[i]; in_sof = 1'b0; out_rdy = 1'b1;
      tick;
      in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b0) begin
        failures++;
        $display("FAIL latency_c1_v%0d: got vld=%b expected 0", i, out_vld);
      end
      tick;
      checks++;
      if (out_vld !== 1'b0) begin
        failures++;
        $display("FAIL latency_c2_v%0d: got vld=%b expected 0", i, out_vld);
      end
      tick;
      checks++;
      if (out_vld !== 1'b1 || out_pxl !== vexp[i]) begin
        failures++;
        $display("FAIL value_v%0d: got vld=%b rgb=%h expected vld=1 rgb=%h", i, out_vld, out_pxl, vexp[i]);
      end
      tick;
`ifdef SYN_YCBCR2RGB_STATS_EN
      exp_pxl++;
      exp_clip += vclip[i];
      checks++;
      if (int'(pxl_cnt) != exp_pxl || int'(clip_cnt) != exp_clip) begin
        failures++;
        $display("FAIL counters_v%0d: got pxl=%0d clip=%0d expected pxl=%0d clip=%0d",
                 i, pxl_cnt, clip_cnt, exp_pxl, exp_clip);
      end
`endif
    end
  endtask

  task automatic test_sof_burst;
    int n;
    out_q.delete(); out_sof_q.delete();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_pxl = vin[i+1]; in_sof = (i == 0);
      tick;
    end
    in_vld = 1'b0; in_sof = 1'b0;
    n = 0;
    while (out_q.size() < 4 && n < 20) begin tick; n++; end
    repeat (4) tick;
    checks++;
    if (out_q.size() != 4) begin
      failures++;
      $display("FAIL sof_count: got %0d outputs expected 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_sof_q[i] !== (i == 0) || out_q[i] !== vexp[i+1]) begin
          failures++;
          $display("FAIL sof_out%0d: got sof=%b rgb=%h expected sof=%b rgb=%h",
                   i, out_sof_q[i], out_q[i], (i == 0), vexp[i+1]);
        end
      end
    end
`ifdef SYN_YCBCR2RGB_STATS_EN
    exp_pxl += 4;
`endif
  endtask

  task automatic test_back_to_back;
    int n, not_rdy;
    out_q.delete(); out_cyc_q.delete(); acc_q.delete();
    out_rdy = 1'b1; in_sof = 1'b0; not_rdy = 0;
    for (int i = 0; i < 256; i++) begin
      in_vld = 1'b1; in_pxl = 8'(i);
      if (in_rdy !== 1'b1) not_rdy++;
      tick;
    end
    in_vld = 1'b0;
    n = 0;
    while (out_q.size() < 256 && n < 50) begin tick; n++; end
    repeat (3) tick;
    checks++;
    if (not_rdy != 0 || acc_q.size() != 256) begin
      failures++;
      $display("FAIL sweep_accept: got not_rdy=%0d accepted=%0d expected 0/256", not_rdy, acc_q.size());
    end
    checks++;
    if (out_q.size() != 256) begin
      failures++;
      $display("FAIL sweep_count: got %0d outputs expected 256", out_q.size());
    end else begin
      checks++;
      if (out_cyc_q[255] - out_cyc_q[0] != 255) begin
        failures++;
        $display("FAIL sweep_rate: got span=%0d cycles expected 255", out_cyc_q[255] - out_cyc_q[0]);
      end
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (!near_model(out_q[i], 8'(i))) begin
          failures++;
          $display("FAIL sweep_code%0d: got rgb=%h expected %h%h%h +/-1", i, out_q[i],
                   4'(model_chan(8'(i), 0)), 4'(model_chan(8'(i), 1)), 4'(model_chan(8'(i), 2)));
        end
      end
    end
`ifdef SYN_YCBCR2RGB_STATS_EN
    exp_pxl += 256;
    checks++;
    if (int'(pxl_cnt) != exp_pxl) begin
      failures++;
      $display("FAIL sweep_pxl_cnt: got %0d expected %0d", pxl_cnt, exp_pxl);
    end
`endif
  endtask

  task automatic test_backpressure;
    int          sent, n, bad_rdy, bad_hold;
    logic        prev_stall, exp_rdy;
    logic [11:0] prev_pxl;
    logic [7:0]  code;
    out_q.delete(); acc_q.delete();
    sent = 0; n = 0; bad_rdy = 0; bad_hold = 0; prev_stall = 1'b0; prev_pxl = '0;
    in_sof = 1'b0;
    while (sent < 64 && n < 1000) begin
      in_vld  = 1'b1;
      in_pxl  = 8'((sent * 37 + 11) & 255);
      out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = ~(out_vld & ~out_rdy);
      checks++;
      if (in_rdy !== exp_rdy) begin
        failures++; bad_rdy++;
        $display("FAIL bp_rdy_cyc%0d: got rdy=%b expected %b", n, in_rdy, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (out_vld !== 1'b1 || out_pxl !== prev_pxl) begin
          failures++; bad_hold++;
          $display("FAIL bp_hold_cyc%0d: got vld=%b rgb=%h expected vld=1 rgb=%h", n, out_vld, out_pxl, prev_pxl);
        end
      end
      prev_stall = out_vld & ~out_rdy;
      prev_pxl   = out_pxl;
      if (in_rdy === 1'b1) sent++;
      @(posedge clk);
      #1;
      n++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    n = 0;
    while (out_q.size() < 64 && n < 30) begin tick; n++; end
    repeat (3) tick;
    checks++;
    if (acc_q.size() != 64 || out_q.size() != 64) begin
      failures++;
      $display("FAIL bp_count: got accepted=%0d delivered=%0d expected 64/64", acc_q.size(), out_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        code = 8'((i * 37 + 11) & 255);
        checks++;
        if (!near_model(out_q[i], code)) begin
          failures++;
          $display("FAIL bp_order%0d: got rgb=%h for code %h expected %h%h%h +/-1", i, out_q[i], code,
                   4'(model_chan(code, 0)), 4'(model_chan(code, 1)), 4'(model_chan(code, 2)));
        end
      end
    end
`ifdef SYN_YCBCR2RGB_STATS_EN
    exp_pxl += 64;
    checks++;
    if (int'(pxl_cnt) != exp_pxl) begin
      failures++;
      $display("FAIL bp_pxl_cnt: got %0d expected %0d", pxl_cnt, exp_pxl);
    end
`endif
  endtask

  task automatic test_reset_mid;
    out_q.delete(); acc_q.delete();
    out_rdy = 1'b0; in_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_pxl = vin[i];
      tick;
    end
    in_vld = 1'b0;
    checks++;
    if (acc_q.size() != 3 || out_vld !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_fill: got accepted=%0d vld=%b expected 3/1", acc_q.size(), out_vld);
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if (out_vld !== 1'b0 || out_pxl !== 12'h000 || out_sof !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got vld=%b pxl=%h sof=%b expected 0/000/0", out_vld, out_pxl, out_sof);
    end
`ifdef SYN_YCBCR2RGB_STATS_EN
    checks++;
    if (clip_cnt !== 16'd0 || pxl_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_counters: got clip=%0d pxl=%0d expected 0/0", clip_cnt, pxl_cnt);
    end
`endif
    rst_n = 1'b1; out_rdy = 1'b1;
    repeat (8) tick;
    checks++;
    if (out_q.size() != 0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_flush: got outputs=%0d vld=%b rdy=%b expected 0/0/1", out_q.size(), out_vld, in_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sof_burst();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
